multicycle_control: RTL and testbench

- Control unit for the multicycle RV32 datapath; drives the 4-bit ALUControl code that the ALU consumes, plus all datapath selects and write enables.
- Moore-style FSM sequences each instruction through fetch, decode, execute, memory and writeback.
- A combinational ALU-decode stage maps instruction fields to the ALU operation codes.
- Sits between the instruction register and the datapath; the Zero flag returns from the ALU.

---
 rtl/riscv_ctrl_pkg.sv | 60 ++++++
 rtl/alu_decoder.sv | 68 ++++++
 rtl/multicycle_control.sv | 151 +++++++++++++++
 tb/tb_multicycle_control.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control unit: opcodes, ALU codes,
// datapath select encodings and the FSM state type.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0011;
  localparam logic [3:0] ALU_DIV = 4'b0100;
  localparam logic [3:0] ALU_REM = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decode: instruction fields -> ALUControl plus an illegal-funct
// flag. Define MULDIV_EN to accept R-type div/rem (funct7b0=1).
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       funct7b0_i,
  input  aluop_t     aluop_i,
  output logic [3:0] alu_control_o,
  output logic       funct_illegal_o
);

  logic [3:0] alu_d;
  logic       ill_d;

  always_comb begin
    alu_d = ALU_ADD;
    ill_d = 1'b0;
    case (aluop_i)
      ALUOP_ADD: alu_d = ALU_ADD;
      ALUOP_SUB: alu_d = ALU_SUB;
      default: begin
        if (op_i == OP_RTYPE) begin
          if (funct7b0_i) begin
            ill_d = 1'b1;
`ifdef MULDIV_EN
            if (!funct7b5_i && funct3_i == 3'b100) begin
              alu_d = ALU_DIV;
              ill_d = 1'b0;
            end else if (!funct7b5_i && funct3_i == 3'b110) begin
              alu_d = ALU_REM;
              ill_d = 1'b0;
            end
`endif
          end else begin
            case (funct3_i)
              3'b000: alu_d = funct7b5_i ? ALU_SUB : ALU_ADD;
              3'b111: begin alu_d = ALU_AND; ill_d = funct7b5_i; end
              3'b010: begin alu_d = ALU_SLT; ill_d = funct7b5_i; end
              3'b001: begin alu_d = ALU_SLL; ill_d = funct7b5_i; end
              3'b101: alu_d = funct7b5_i ? ALU_SRA : ALU_SRL;
              default: ill_d = 1'b1;
            endcase
          end
        end else if (op_i == OP_ITYPE) begin
          // instr[30]/instr[25] are immediate bits here; only srai looks at bit 30
          case (funct3_i)
            3'b000: alu_d = ALU_ADD;
            3'b111: alu_d = ALU_AND;
            3'b010: alu_d = ALU_SLT;
            3'b001: alu_d = ALU_SLL;
            3'b101: alu_d = funct7b5_i ? ALU_SRA : ALU_SRL;
            default: ill_d = 1'b1;
          endcase
        end else begin
          ill_d = 1'b1;
        end
        if (ill_d) alu_d = ALU_ADD;
      end
    endcase
  end

  assign alu_control_o   = alu_d;
  assign funct_illegal_o = ill_d;

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM controller for the multicycle RV32 datapath. Build option MULDIV_EN
// (see alu_decoder) enables div/rem; ILLEGAL_HALT picks park-vs-resume on illegal.
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned ILLEGAL_HALT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       funct7b0,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [3:0] ALUControl,
  output logic       illegal_instr,
  output logic [3:0] state_dbg
);

  state_t     state_q, state_d, cur;
  aluop_t     aluop;
  logic [3:0] dec_alu;
  logic       funct_ill;
  logic       pcw, irw, memw, regw;

  alu_decoder u_alu_decoder (
    .op_i            (op),
    .funct3_i        (funct3),
    .funct7b5_i      (funct7b5),
    .funct7b0_i      (funct7b0),
    .aluop_i         (aluop),
    .alu_control_o   (dec_alu),
    .funct_illegal_o (funct_ill)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = (funct3 == 3'b000) ? S_BEQ : S_ILLEGAL;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER,
      S_EXECUTEI: state_d = funct_ill ? S_ILLEGAL : S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: state_d = S_FETCH;
      S_ILLEGAL:  state_d = (ILLEGAL_HALT != 0) ? S_ILLEGAL : S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Outputs decode the FETCH view while reset is high so the datapath sees
  // fetch selects immediately; the write enables are then gated separately.
  always_comb begin
    cur       = reset ? S_FETCH : state_q;
    pcw       = 1'b0;
    irw       = 1'b0;
    memw      = 1'b0;
    regw      = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ImmSrc    = IMM_I;
    aluop     = ALUOP_ADD;
    case (cur)
      S_FETCH: begin
        irw       = 1'b1;
        pcw       = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_B;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_READDATA;
        regw      = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        memw   = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_I;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: regw = 1'b1;
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        aluop   = ALUOP_SUB;
        pcw     = Zero;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        ImmSrc  = IMM_J;
        pcw     = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWrite       = pcw  & ~reset;
  assign IRWrite       = irw  & ~reset;
  assign MemWrite      = memw & ~reset;
  assign RegWrite      = regw & ~reset;
  assign ALUControl    = dec_alu;
  assign illegal_instr = (cur == S_ILLEGAL);
  assign state_dbg     = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control; honours MULDIV_EN.
module tb_multicycle_control;
  import riscv_ctrl_pkg::*;

  logic       clk, reset, funct7b5, funct7b0, Zero;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [3:0] ALUControl, state_dbg;
  logic       nh_PCWrite, nh_AdrSrc, nh_MemWrite, nh_IRWrite, nh_RegWrite, nh_illegal;
  logic [1:0] nh_ResultSrc, nh_ALUSrcA, nh_ALUSrcB, nh_ImmSrc;
  logic [3:0] nh_ALUControl, nh_state;

  multicycle_control #(.ILLEGAL_HALT(1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .funct7b0(funct7b0), .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALUControl(ALUControl),
    .illegal_instr(illegal_instr), .state_dbg(state_dbg)
  );

  multicycle_control #(.ILLEGAL_HALT(0)) dut_nh (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .funct7b0(funct7b0), .Zero(Zero), .PCWrite(nh_PCWrite), .AdrSrc(nh_AdrSrc),
    .MemWrite(nh_MemWrite), .IRWrite(nh_IRWrite), .ResultSrc(nh_ResultSrc),
    .ALUSrcA(nh_ALUSrcA), .ALUSrcB(nh_ALUSrcB), .ImmSrc(nh_ImmSrc),
    .RegWrite(nh_RegWrite), .ALUControl(nh_ALUControl), .illegal_instr(nh_illegal),
    .state_dbg(nh_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        b5;
    logic        b0;
    logic        zero;
    int unsigned n;
    logic [19:0] path;
    logic [3:0]  alu;
    logic [1:0]  srcb;
    logic [1:0]  imm;
  } vec_t;

  localparam int unsigned NV = 22;
  vec_t vt[NV];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cur_vec  = -1;
  state_t s;

  function automatic logic [19:0] P(input state_t a, input state_t b, input state_t c,
                                    input state_t d, input state_t e);
    return {e, d, c, b, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vector %0d, t=%0t): got %0h expected %0h", nm, cur_vec, $time, act, exp);
    end
  endtask

  initial begin
    vt[0]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 5, P(S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB), 4'b0000, 2'b01, 2'b00};
    vt[1]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 4, P(S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE, S_FETCH), 4'b0000, 2'b01, 2'b01};
    vt[2]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 4, P(S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB, S_FETCH), 4'b0000, 2'b00, 2'b00};
    vt[3]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 4, P(S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB, S_FETCH), 4'b0010, 2'b00, 2'b00};
    vt[4]  = '{7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, 4, P(S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB, S_FETCH), 4'b0001, 2'b00, 2'b00};
    vt[5]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 1'b0, 4, P(S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB, S_FETCH), 4'b0011, 2'b00, 2'b00};
    vt[6]  = '{7'b0110011, 3'b001, 1'b0, 1'b0, 1'b0, 4, P(S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB, S_FETCH), 4'b0111, 2'b00, 2'b00};
    vt[7]  = '{7'b0110011, 3'b101, 1'b0, 1'b0, 1'b0, 4, P(S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB, S_FETCH), 4'b1000, 2'b00, 2'b00};
    vt[8]  = '{7'b0110011, 3'b101, 1'b1, 1'b0, 1'b0, 4, P(S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB, S_FETCH), 4'b0110, 2'b00, 2'b00};
    vt[9]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 4, P(S_FETCH, S_DECODE, S_EXECUTEI, S_ALUWB, S_FETCH), 4'b0000, 2'b01, 2'b00};
    vt[10] = '{7'b0010011, 3'b101, 1'b1, 1'b0, 1'b0, 4, P(S_FETCH, S_DECODE, S_EXECUTEI, S_ALUWB, S_FETCH), 4'b0110, 2'b01, 2'b00};
    vt[11] = '{7'b0010011, 3'b101, 1'b0, 1'b0, 1'b0, 4, P(S_FETCH, S_DECODE, S_EXECUTEI, S_ALUWB, S_FETCH), 4'b1000, 2'b01, 2'b00};
    vt[12] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 1'b1, 3, P(S_FETCH, S_DECODE, S_BEQ, S_FETCH, S_FETCH), 4'b0010, 2'b00, 2'b00};
    vt[13] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, 3, P(S_FETCH, S_DECODE, S_BEQ, S_FETCH, S_FETCH), 4'b0010, 2'b00, 2'b00};
    vt[14] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 4, P(S_FETCH, S_DECODE, S_JAL, S_ALUWB, S_FETCH), 4'b0000, 2'b10, 2'b11};
`ifdef MULDIV_EN
    vt[15] = '{7'b0110011, 3'b100, 1'b0, 1'b1, 1'b0, 4, P(S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB, S_FETCH), 4'b0100, 2'b00, 2'b00};
    vt[16] = '{7'b0110011, 3'b110, 1'b0, 1'b1, 1'b0, 4, P(S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB, S_FETCH), 4'b0101, 2'b00, 2'b00};
`else
    vt[15] = '{7'b0110011, 3'b100, 1'b0, 1'b1, 1'b0, 4, P(S_FETCH, S_DECODE, S_EXECUTER, S_ILLEGAL, S_FETCH), 4'b0000, 2'b00, 2'b00};
    vt[16] = '{7'b0110011, 3'b110, 1'b0, 1'b1, 1'b0, 4, P(S_FETCH, S_DECODE, S_EXECUTER, S_ILLEGAL, S_FETCH), 4'b0000, 2'b00, 2'b00};
`endif
    vt[17] = '{7'b0110011, 3'b100, 1'b0, 1'b0, 1'b0, 4, P(S_FETCH, S_DECODE, S_EXECUTER, S_ILLEGAL, S_FETCH), 4'b0000, 2'b00, 2'b00};
    vt[18] = '{7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 4, P(S_FETCH, S_DECODE, S_ILLEGAL, S_ILLEGAL, S_FETCH), 4'b0000, 2'b00, 2'b00};
    vt[19] = '{7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 3, P(S_FETCH, S_DECODE, S_ILLEGAL, S_FETCH, S_FETCH), 4'b0000, 2'b00, 2'b00};
    vt[20] = '{7'b0010011, 3'b110, 1'b0, 1'b0, 1'b0, 4, P(S_FETCH, S_DECODE, S_EXECUTEI, S_ILLEGAL, S_FETCH), 4'b0000, 2'b01, 2'b00};
    vt[21] = '{7'b0010011, 3'b010, 1'b0, 1'b0, 1'b0, 4, P(S_FETCH, S_DECODE, S_EXECUTEI, S_ALUWB, S_FETCH), 4'b0011, 2'b01, 2'b00};

    // Reset held for three cycles: write enables off, FETCH view on outputs
    reset = 1'b1; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; funct7b0 = 1'b0; Zero = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("reset_enables", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
      chk("reset_state", 32'(state_dbg), 32'(S_FETCH));
      chk("reset_illegal", 32'(illegal_instr), 32'd0);
      chk("reset_fetch_sel", 32'({ALUSrcA, ALUSrcB, ResultSrc, AdrSrc}), 32'b00_10_10_0);
    end

    for (int i = 0; i < int'(NV); i++) begin
      cur_vec = i;
      op = vt[i].op; funct3 = vt[i].f3; funct7b5 = vt[i].b5; funct7b0 = vt[i].b0; Zero = vt[i].zero;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      for (int c = 0; c < int'(vt[i].n); c++) begin
        if (c > 0) begin @(posedge clk); #1; end
        s = state_t'(vt[i].path[c*4 +: 4]);
        chk("state", 32'(state_dbg), 32'(s));
        chk("RegWrite", 32'(RegWrite), 32'(s == S_ALUWB || s == S_MEMWB));
        chk("PCWrite", 32'(PCWrite), 32'(s == S_FETCH || s == S_JAL || (s == S_BEQ && vt[i].zero)));
        chk("MemWrite", 32'(MemWrite), 32'(s == S_MEMWRITE));
        chk("IRWrite", 32'(IRWrite), 32'(s == S_FETCH));
        chk("AdrSrc", 32'(AdrSrc), 32'(s == S_MEMREAD || s == S_MEMWRITE));
        chk("ResultSrc", 32'(ResultSrc), (s == S_FETCH) ? 32'd2 : (s == S_MEMWB) ? 32'd1 : 32'd0);
        chk("illegal_instr", 32'(illegal_instr), 32'(s == S_ILLEGAL));
        if (c == 1) chk("decode_sel", 32'({ALUSrcA, ALUSrcB, ImmSrc}), 32'b01_01_10);
        if (c == 2) begin
          chk("ALUControl", 32'(ALUControl), 32'(vt[i].alu));
          chk("ALUSrcB", 32'(ALUSrcB), 32'(vt[i].srcb));
          chk("ImmSrc", 32'(ImmSrc), 32'(vt[i].imm));
        end
      end
    end

    // Reset arriving during ALUWB must kill the register write immediately
    cur_vec = 100;
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; funct7b0 = 1'b0;
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("aluwb_regwrite", 32'(RegWrite), 32'd1);
    reset = 1'b1; #1;
    chk("reset_kills_regwrite", 32'(RegWrite), 32'd0);
    chk("reset_kills_irwrite", 32'(IRWrite), 32'd0);
    chk("reset_view_fetch", 32'(state_dbg), 32'(S_FETCH));
    @(posedge clk); #1; reset = 1'b0;

    // Illegal opcode: halting instance parks, non-halting instance resumes fetch
    cur_vec = 101;
    op = 7'b1111111;
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0; #1;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c >= 2) begin
        chk("halt_state", 32'(state_dbg), 32'(S_ILLEGAL));
        chk("halt_flag", 32'(illegal_instr), 32'd1);
        chk("halt_no_pcwrite", 32'(PCWrite), 32'd0);
      end
      case (c % 3)
        0: chk("nohalt_state", 32'(nh_state), 32'(S_FETCH));
        1: chk("nohalt_state", 32'(nh_state), 32'(S_DECODE));
        default: chk("nohalt_state", 32'(nh_state), 32'(S_ILLEGAL));
      endcase
      chk("nohalt_flag", 32'(nh_illegal), 32'(c % 3 == 2));
    end
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0; #1;
    chk("halt_cleared_state", 32'(state_dbg), 32'(S_FETCH));
    chk("halt_cleared_flag", 32'(illegal_instr), 32'd0);
    @(posedge clk); #1;
    chk("halt_resume_decode", 32'(state_dbg), 32'(S_DECODE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
